// File: rtl/multicycle_control_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer for the 16-bit TSC datapath.
// Ports: clk, reset_n (async, 1 = reset), opcode/func_code/bcond/mem_ready in;
//        datapath enables, wwd/halt, inst_done, num_inst, state_out out.
module multicycle_control_fsm #(
    parameter int IF_CYCLES     = 2,
    parameter int MEM_CYCLES    = 4,
    parameter bit USE_MEM_READY = 1'b0,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       opcode,
    input  logic [5:0]       func_code,
    input  logic             bcond,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             reg_write,
    output logic [1:0]       wb_src,
    output logic [1:0]       reg_dst,
    output logic             wwd,
    output logic             halt,
    output logic             inst_done,
    output logic [CNT_W-1:0] num_inst,
    output logic [2:0]       state_out
);

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_BGZ = 4'd2;
    localparam logic [3:0] OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_RTY = 4'd15;

    localparam logic [5:0] FN_SHR = 6'd7;
    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    localparam int MAXC = (IF_CYCLES > MEM_CYCLES) ? IF_CYCLES : MEM_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] IF_LAST  = CW'(IF_CYCLES - 1);
    localparam logic [CW-1:0] MEM_LAST = CW'(MEM_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX1  = 3'd2,
        S_EX2  = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_RALU, C_IMM, C_LWD, C_SWD, C_BR, C_JMP,
        C_JAL, C_JPR, C_JRL, C_WWD, C_HLT, C_BAD
    } cls_t;

    function automatic cls_t classify(input logic [3:0] op,
                                      input logic [5:0] fn);
        cls_t c;
        c = C_BAD;
        case (op)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: c = C_BR;
            OP_ADI, OP_ORI, OP_LHI:         c = C_IMM;
            OP_LWD:                         c = C_LWD;
            OP_SWD:                         c = C_SWD;
            OP_JMP:                         c = C_JMP;
            OP_JAL:                         c = C_JAL;
            OP_RTY: begin
                if (fn <= FN_SHR)       c = C_RALU;
                else if (fn == FN_JPR)  c = C_JPR;
                else if (fn == FN_JRL)  c = C_JRL;
                else if (fn == FN_WWD)  c = C_WWD;
                else if (fn == FN_HLT)  c = C_HLT;
                else                    c = C_BAD;
            end
            default:                        c = C_BAD;
        endcase
        return c;
    endfunction

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [CNT_W-1:0] num_inst_q;

    cls_t cls;
    logic if_last;
    logic mem_last;
    logic if_exit;
    logic mem_exit;

    // bcond reaches the PC through pc_write_cond in the datapath
    logic unused_bcond;
    assign unused_bcond = bcond;

    assign cls      = classify(opcode, func_code);
    assign if_last  = (cnt_q == IF_LAST);
    assign mem_last = (cnt_q == MEM_LAST);
    // mem_ready only matters on the final sub-cycle of a phase
    assign if_exit  = if_last  && (!USE_MEM_READY || mem_ready);
    assign mem_exit = mem_last && (!USE_MEM_READY || mem_ready);

    assign num_inst = num_inst_q;

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        pc_source     = 2'd0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        wb_src        = 2'd0;
        reg_dst       = 2'd0;
        wwd           = 1'b0;
        halt          = 1'b0;
        inst_done     = 1'b0;
        state_out     = 3'd0;
        if (!reset_n) begin
            state_out = state_q;
            unique case (state_q)
                S_IF: begin
                    mem_read = 1'b1;
                    ir_write = if_exit;
                end
                S_ID: begin
                    alu_src_b = 2'd1;
                    pc_source = 2'd1;
                    pc_write  = 1'b1;
                    inst_done = (cls == C_HLT) || (cls == C_BAD);
                end
                S_EX1: begin
                    unique case (cls)
                        C_RALU: alu_src_a = 1'b1;
                        C_IMM, C_LWD, C_SWD: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'd2;
                        end
                        C_BR: alu_src_b = 2'd2;
                        C_JMP, C_JPR: begin
                            pc_source = (cls == C_JMP) ? 2'd2 : 2'd3;
                            pc_write  = 1'b1;
                            inst_done = 1'b1;
                        end
                        C_JAL, C_JRL: begin
                            pc_source = (cls == C_JAL) ? 2'd2 : 2'd3;
                            pc_write  = 1'b1;
                            reg_write = 1'b1;
                            wb_src    = 2'd2;
                            reg_dst   = 2'd2;
                            inst_done = 1'b1;
                        end
                        C_WWD: begin
                            wwd       = 1'b1;
                            inst_done = 1'b1;
                        end
                        default: inst_done = 1'b1;
                    endcase
                end
                S_EX2: begin
                    alu_src_a     = 1'b1;
                    pc_write_cond = 1'b1;
                    inst_done     = 1'b1;
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = (cls == C_LWD);
                    mem_write = (cls == C_SWD);
                    inst_done = (cls == C_SWD) && mem_exit;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    inst_done = 1'b1;
                    wb_src    = (cls == C_LWD) ? 2'd1 : 2'd0;
                    reg_dst   = (cls == C_RALU) ? 2'd1 : 2'd0;
                end
                S_HALT: halt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q    <= S_IF;
            cnt_q      <= '0;
            num_inst_q <= '0;
        end else begin
            num_inst_q <= num_inst_q + CNT_W'(inst_done);
            unique case (state_q)
                S_IF: begin
                    if (if_exit) begin
                        state_q <= S_ID;
                        cnt_q   <= '0;
                    end else if (!if_last) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ID: begin
                    if (cls == C_HLT)      state_q <= S_HALT;
                    else if (cls == C_BAD) state_q <= S_IF;
                    else                   state_q <= S_EX1;
                end
                S_EX1: begin
                    unique case (cls)
                        C_RALU, C_IMM: state_q <= S_WB;
                        C_LWD, C_SWD:  state_q <= S_MEM;
                        C_BR:          state_q <= S_EX2;
                        default:       state_q <= S_IF;
                    endcase
                end
                S_EX2: state_q <= S_IF;
                S_MEM: begin
                    if (mem_exit) begin
                        state_q <= (cls == C_LWD) ? S_WB : S_IF;
                        cnt_q   <= '0;
                    end else if (!mem_last) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WB:   state_q <= S_IF;
                S_HALT: state_q <= S_HALT;
                default: begin
                    state_q <= S_IF;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
